// File: rtl/fp_isqrt_nr_refine_if.sv
// fp_isqrt_nr_refine_if: operand/result handshake bundle for fp_isqrt_nr_refine.
//   in_valid/in_ready : operand pair handshake (din_x = x, din_y = seed y0)
//   out_valid/out_ready: result handshake (dout = refined 1/sqrt(x), dout_err = x <= 0)
//   master: upstream/downstream side, slave: the refinement block.
interface fp_isqrt_nr_refine_if #(
    parameter int unsigned WI  = 10,
    parameter int unsigned WF  = 10,
    parameter int unsigned WIO = 10,
    parameter int unsigned WFO = 10
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [WI+WF-1:0]     din_x;
    logic signed [WIO+WFO-1:0]   din_y;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [WIO+WFO-1:0]   dout;
    logic                        dout_err;

    modport master (
        output in_valid, din_x, din_y, out_ready,
        input  in_ready, out_valid, dout, dout_err
    );

    modport slave (
        input  in_valid, din_x, din_y, out_ready,
        output in_ready, out_valid, dout, dout_err
    );
endinterface

// File: rtl/fp_isqrt_nr_refine.sv
// fp_isqrt_nr_refine: Newton-Raphson refinement of a coarse 1/sqrt(x) seed,
// y <- y*(1.5 - 0.5*x*y^2), ITER iterations on one shared multiplier.
// Ports:
//   CLK  : clock, rising edge
//   nRST : synchronous active-low reset
//   CE   : clock enable, all registers hold when low
//   bus  : fp_isqrt_nr_refine_if.slave (in_valid/in_ready/din_x/din_y,
//          out_valid/out_ready/dout/dout_err)
// Build option: define ISQRT_NR_ROUND_EN to round half-up on the final
// reduction to WFO fraction bits; otherwise the result is truncated.
module fp_isqrt_nr_refine #(
    parameter int unsigned WI   = 10,
    parameter int unsigned WF   = 10,
    parameter int unsigned WIO  = 10,
    parameter int unsigned WFO  = 10,
    parameter int unsigned GB   = 4,
    parameter int unsigned ITER = 1
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               CE,
    fp_isqrt_nr_refine_if.slave bus
);
    localparam int unsigned XW = WI + WF;           // x width
    localparam int unsigned FP = WFO + GB;          // internal fraction bits
    localparam int unsigned W  = WIO + FP;          // internal y/p width
    localparam int unsigned OW = WIO + WFO;         // output width
    localparam int unsigned AW = (XW > W) ? XW : W; // multiplier A width
    localparam int unsigned PW = AW + W;            // full product width
    localparam int unsigned CW = 3;                 // iteration counter width

    localparam logic [CW-1:0]        ITER_C    = CW'(ITER);
    localparam logic [W-1:0]         SAT_MAX_W = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MAX_P = PW'(SAT_MAX_W);
    localparam logic signed [W-1:0]  ONE_P5    = W'(3) << (FP - 1);

    typedef enum logic [2:0] {IDLE, SQ, MX, SUB, MY, OUT} state_t;

    state_t                 state, state_d;
    logic signed [XW-1:0]   x_q, x_d;
    logic signed [W-1:0]    y_q, y_d, p_q, p_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic                   out_valid_q;
    logic [OW-1:0]          dout_q, dout_d;
    logic                   err_q, err_d;

    logic signed [AW-1:0]   mul_a;
    logic signed [W-1:0]    mul_b;
    logic signed [PW-1:0]   prod, prod_sh;
    logic signed [W:0]      sub_v;
    logic signed [W-1:0]    res;
    logic [OW-1:0]          red;

    // Clamp negatives to 0 and saturate to the largest positive internal value.
    function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
        if (v[PW-1])
            return '0;
        else if (v > SAT_MAX_P)
            return SAT_MAX_W;
        else
            return W'(v);
    endfunction

    // Shared multiplier: SQ y*y, MX x*p, MY y*p; SUB uses the subtractor.
    always_comb begin
        mul_a   = (state == MX) ? AW'(x_q) : AW'(y_q);
        mul_b   = (state == SQ) ? y_q : p_q;
        prod    = PW'(mul_a) * PW'(mul_b);
        prod_sh = (state == MX) ? (prod >>> WF) : (prod >>> FP);
        sub_v   = (W+1)'(ONE_P5) - (W+1)'(p_q >>> 1);
        res     = sat_w((state == SUB) ? PW'(sub_v) : prod_sh);
    end

    // Final reduction of the new y to WFO fraction bits.
`ifdef ISQRT_NR_ROUND_EN
    localparam logic [W:0]    RND_HALF = (W+1)'(1) << (GB - 1);
    localparam logic [OW-1:0] SAT_OUT  = {1'b0, {(OW-1){1'b1}}};
    logic [OW:0] red_wide;
    always_comb begin
        red_wide = (OW+1)'(({1'b0, res} + RND_HALF) >> GB);
        red      = (red_wide[OW] | red_wide[OW-1]) ? SAT_OUT : red_wide[OW-1:0];
    end
`else
    always_comb begin
        red = OW'(res >> GB);
    end
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state;
        x_d     = x_q;
        y_d     = y_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        err_d   = err_q;
        cnt_inc = cnt_q + CW'(1);
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d   = bus.din_x;
                    y_d   = {bus.din_y, {GB{1'b0}}};
                    cnt_d = '0;
                    if (bus.din_x[XW-1] || (bus.din_x == '0)) begin
                        state_d = OUT;
                        dout_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SQ;
                    end
                end
            end
            SQ: begin
                p_d     = res;
                state_d = MX;
            end
            MX: begin
                p_d     = res;
                state_d = SUB;
            end
            SUB: begin
                p_d     = res;
                state_d = MY;
            end
            MY: begin
                y_d   = res;
                cnt_d = cnt_inc;
                if (cnt_inc < ITER_C) begin
                    state_d = SQ;
                end else begin
                    state_d = OUT;
                    dout_d  = red;
                    err_d   = 1'b0;
                end
            end
            OUT: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            err_q       <= 1'b0;
        end else if (CE) begin
            state       <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            out_valid_q <= (state_d == OUT);
            dout_q      <= dout_d;
            err_q       <= err_d;
        end
    end

    // in_ready is dropped immediately while reset is held.
    assign bus.in_ready  = (state == IDLE) && nRST;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.dout_err  = err_q;
endmodule
